// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ready handshake and
// holds the instruction for control_unit until the datapath retires it.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          TIMEOUT  = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic [5:0]  opcode,
   output logic        instr_valid,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   input  logic        retire,
   input  logic        stall,
   input  logic        branch,
   input  logic        zero,
   input  logic        jump,
   output logic        fetch_err
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      HOLD  = 2'd2,
      ERR   = 2'd3
   } state_t;

   localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);
   localparam logic       TIMEOUT_EN   = (TIMEOUT != 0);

   state_t      state_r, state_s;
   logic [31:0] pc_r, pc_s;
   logic [31:0] instr_r, instr_s;
   logic        instr_valid_r, instr_valid_s;
   logic        fetch_err_r, fetch_err_s;
   logic [7:0]  wait_cnt_r, wait_cnt_s;
   logic [31:0] pc_plus4_s;
   logic [31:0] next_pc_s;

   function automatic logic [31:0] jump_target(input logic [31:0] pc4, input logic [25:0] idx);
      return {pc4[31:28], idx, 2'b00};
   endfunction

   function automatic logic [31:0] branch_target(input logic [31:0] pc4, input logic [15:0] imm);
      return pc4 + {{14{imm[15]}}, imm, 2'b00};
   endfunction

   assign pc_plus4_s = pc_r + 32'd4;

   // Next-PC select; jump is tested first so an undefined branch on jal never leaks in.
   always_comb begin
      next_pc_s = pc_plus4_s;
      if (jump == 1'b1) begin
         next_pc_s = jump_target(pc_plus4_s, instr_r[25:0]);
      end else if ((branch == 1'b1) && (zero == 1'b1)) begin
         next_pc_s = branch_target(pc_plus4_s, instr_r[15:0]);
      end else begin
         next_pc_s = pc_plus4_s;
      end
   end

   // Next-state and next-register computation for the fetch FSM.
   always_comb begin
      state_s       = state_r;
      pc_s          = pc_r;
      instr_s       = instr_r;
      instr_valid_s = instr_valid_r;
      fetch_err_s   = fetch_err_r;
      wait_cnt_s    = wait_cnt_r;
      case (state_r)
         IDLE: begin
            wait_cnt_s = 8'd0;
            state_s    = FETCH;
         end
         FETCH: begin
            instr_valid_s = 1'b0;
            if (imem_ready == 1'b1) begin
               instr_s       = imem_rdata;
               instr_valid_s = 1'b1;
               wait_cnt_s    = 8'd0;
               state_s       = HOLD;
            end else if (TIMEOUT_EN && (wait_cnt_r == TIMEOUT_LAST)) begin
               fetch_err_s = 1'b1;
               state_s     = ERR;
            end else begin
               wait_cnt_s = wait_cnt_r + 8'd1;
            end
         end
         HOLD: begin
            // Retire under stall is dropped, not remembered.
            if ((retire == 1'b1) && (stall == 1'b0)) begin
               pc_s          = next_pc_s;
               instr_valid_s = 1'b0;
               wait_cnt_s    = 8'd0;
               state_s       = FETCH;
            end else begin
               state_s = HOLD;
            end
         end
         ERR: begin
            instr_valid_s = 1'b0;
            fetch_err_s   = 1'b1;
            state_s       = ERR;
         end
         default: begin
            instr_valid_s = 1'b0;
            fetch_err_s   = 1'b1;
            state_s       = ERR;
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r       <= IDLE;
         pc_r          <= RESET_PC;
         instr_r       <= 32'h0000_0000;
         instr_valid_r <= 1'b0;
         fetch_err_r   <= 1'b0;
         wait_cnt_r    <= 8'd0;
      end else begin
         state_r       <= state_s;
         pc_r          <= pc_s;
         instr_r       <= instr_s;
         instr_valid_r <= instr_valid_s;
         fetch_err_r   <= fetch_err_s;
         wait_cnt_r    <= wait_cnt_s;
      end
   end

   // The request follows the state register, so reset removes it immediately.
   assign imem_req    = (state_r == FETCH);
   assign imem_addr   = pc_r;
   assign instr       = instr_r;
   assign opcode      = instr_r[31:26];
   assign instr_valid = instr_valid_r;
   assign pc          = pc_r;
   assign pc_plus4    = pc_plus4_s;
   assign fetch_err   = fetch_err_r;

   fetch_unit_chk u_chk (
      .clk         (clk),
      .rst_n       (rst_n),
      .imem_req    (imem_req),
      .instr_valid (instr_valid),
      .fetch_err   (fetch_err),
      .pc          (pc_r),
      .instr       (instr_r),
      .opcode      (opcode)
   );

endmodule

// Invariant checks for fetch_unit outputs.
module fetch_unit_chk (
   input logic        clk,
   input logic        rst_n,
   input logic        imem_req,
   input logic        instr_valid,
   input logic        fetch_err,
   input logic [31:0] pc,
   input logic [31:0] instr,
   input logic [5:0]  opcode
);

   a_pc_aligned:   assert property (@(posedge clk) disable iff (!rst_n) pc[1:0] == 2'b00);
   a_opcode:       assert property (@(posedge clk) disable iff (!rst_n) opcode == instr[31:26]);
   a_req_no_valid: assert property (@(posedge clk) disable iff (!rst_n) !(imem_req && instr_valid));
   a_err_quiet:    assert property (@(posedge clk) disable iff (!rst_n) fetch_err |-> (!imem_req && !instr_valid));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, sequential fetch, branch, jal, stall
// and timeout/reset recovery, with hand-computed expectations.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic [31:0] instr;
   logic [5:0]  opcode;
   logic        instr_valid;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        retire;
   logic        stall;
   logic        branch;
   logic        zero;
   logic        jump;
   logic        fetch_err;

   int tests_run = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   fetch_unit #(.RESET_PC(32'h0000_0000), .TIMEOUT(4)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ready  (imem_ready),
      .imem_rdata  (imem_rdata),
      .instr       (instr),
      .opcode      (opcode),
      .instr_valid (instr_valid),
      .pc          (pc),
      .pc_plus4    (pc_plus4),
      .retire      (retire),
      .stall       (stall),
      .branch      (branch),
      .zero        (zero),
      .jump        (jump),
      .fetch_err   (fetch_err)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Waits (bounded) for a request, idles 'waits' cycles, then returns the word.
   task automatic fetch_word(input logic [31:0] word, input int waits);
      int n = 0;
      while (imem_req !== 1'b1 && n < 20) begin
         step();
         n++;
      end
      tests_run++;
      if (imem_req !== 1'b1) begin
         tests_failed++;
         $display("FAIL fetch_wait: imem_req=%b after %0d cycles, required 1", imem_req, n);
      end
      repeat (waits) step();
      imem_ready = 1'b1;
      imem_rdata = word;
      step();
      imem_ready = 1'b0;
      imem_rdata = 32'hDEAD_BEEF;
   endtask

   task automatic do_retire(input logic j, input logic b, input logic z);
      jump   = j;
      branch = b;
      zero   = z;
      retire = 1'b1;
      step();
      retire = 1'b0;
      jump   = 1'b0;
      branch = 1'b0;
      zero   = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #1;
      tests_run++;
      if ({imem_req, instr_valid, fetch_err} !== 3'b000 || pc !== 32'h0 || instr !== 32'h0) begin
         tests_failed++;
         $display("FAIL reset_state: req/valid/err=%b%b%b pc=%h instr=%h, required 000 0 0",
                  imem_req, instr_valid, fetch_err, pc, instr);
      end
      step();
      rst_n = 1'b1;
      tests_run++;
      if (imem_req !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_idle: imem_req=%b, required 0", imem_req);
      end
      step();
      tests_run++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h0 || fetch_err !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_first_fetch: req=%b addr=%h err=%b, required 1 0 0", imem_req, imem_addr, fetch_err);
      end
   endtask

   task automatic test_sequential();
      step();
      tests_run++;
      if (instr_valid !== 1'b0 || imem_req !== 1'b1) begin
         tests_failed++;
         $display("FAIL seq_wait: valid=%b req=%b, required 0 1", instr_valid, imem_req);
      end
      step();
      imem_ready = 1'b1;
      imem_rdata = 32'h2008_0005;
      step();
      imem_ready = 1'b0;
      tests_run++;
      if (instr_valid !== 1'b1 || instr !== 32'h2008_0005 || opcode !== 6'b001000 || imem_req !== 1'b0) begin
         tests_failed++;
         $display("FAIL seq_capture: valid=%b instr=%h op=%b req=%b, required 1 20080005 001000 0",
                  instr_valid, instr, opcode, imem_req);
      end
      tests_run++;
      if (pc !== 32'h0 || pc_plus4 !== 32'h4) begin
         tests_failed++;
         $display("FAIL seq_pc: pc=%h pc_plus4=%h, required 0 4", pc, pc_plus4);
      end
      do_retire(1'b0, 1'b0, 1'b0);
      tests_run++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h4 || instr_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL seq_next: req=%b addr=%h valid=%b, required 1 4 0", imem_req, imem_addr, instr_valid);
      end
   endtask

   task automatic test_branch();
      fetch_word(32'h0800_0010, 0);
      do_retire(1'b1, 1'b0, 1'b0);
      tests_run++;
      if (pc !== 32'h0000_0040) begin
         tests_failed++;
         $display("FAIL j_to_40: pc=%h, required 00000040", pc);
      end
      fetch_word(32'h1000_FFFF, 1);
      tests_run++;
      if (pc_plus4 !== 32'h0000_0044 || opcode !== 6'b000100) begin
         tests_failed++;
         $display("FAIL beq_hold: pc_plus4=%h op=%b, required 00000044 000100", pc_plus4, opcode);
      end
      do_retire(1'b0, 1'b1, 1'b1);
      tests_run++;
      if (imem_addr !== 32'h0000_0040) begin
         tests_failed++;
         $display("FAIL beq_taken: addr=%h, required 00000040", imem_addr);
      end
      fetch_word(32'h1000_FFFF, 0);
      do_retire(1'b0, 1'b1, 1'b0);
      tests_run++;
      if (imem_addr !== 32'h0000_0044) begin
         tests_failed++;
         $display("FAIL beq_not_taken: addr=%h, required 00000044", imem_addr);
      end
   endtask

   task automatic test_jal();
      fetch_word(32'h0810_0004, 0);
      do_retire(1'b1, 1'b0, 1'b0);
      tests_run++;
      if (pc !== 32'h0040_0010) begin
         tests_failed++;
         $display("FAIL j_to_400010: pc=%h, required 00400010", pc);
      end
      fetch_word(32'h0C10_0008, 0);
      tests_run++;
      if (pc_plus4 !== 32'h0040_0014 || opcode !== 6'b000011) begin
         tests_failed++;
         $display("FAIL jal_link: pc_plus4=%h op=%b, required 00400014 000011", pc_plus4, opcode);
      end
      do_retire(1'b1, 1'bx, 1'b1);
      tests_run++;
      if (pc !== 32'h0040_0020) begin
         tests_failed++;
         $display("FAIL jal_target: pc=%h, required 00400020", pc);
      end
   endtask

   task automatic test_stall();
      fetch_word(32'h0000_0020, 0);
      stall  = 1'b1;
      retire = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         tests_run++;
         if (pc !== 32'h0040_0020 || instr !== 32'h0000_0020 || imem_req !== 1'b0 || instr_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL stall_hold%0d: pc=%h instr=%h req=%b valid=%b, required 00400020 00000020 0 1",
                     i, pc, instr, imem_req, instr_valid);
         end
      end
      stall = 1'b0;
      step();
      retire = 1'b0;
      tests_run++;
      if (pc !== 32'h0040_0024 || imem_req !== 1'b1) begin
         tests_failed++;
         $display("FAIL stall_release: pc=%h req=%b, required 00400024 1", pc, imem_req);
      end
   endtask

   task automatic test_timeout();
      for (int i = 0; i < 3; i++) begin
         step();
         tests_run++;
         if (imem_req !== 1'b1 || fetch_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL to_waiting%0d: req=%b err=%b, required 1 0", i, imem_req, fetch_err);
         end
      end
      step();
      tests_run++;
      if (fetch_err !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL to_err: err=%b req=%b valid=%b, required 1 0 0", fetch_err, imem_req, instr_valid);
      end
      imem_ready = 1'b1;
      step();
      step();
      imem_ready = 1'b0;
      tests_run++;
      if (fetch_err !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL to_err_sticky: err=%b req=%b valid=%b, required 1 0 0", fetch_err, imem_req, instr_valid);
      end
      rst_n = 1'b0;
      #1;
      tests_run++;
      if (fetch_err !== 1'b0 || pc !== 32'h0 || imem_req !== 1'b0) begin
         tests_failed++;
         $display("FAIL to_reset: err=%b pc=%h req=%b, required 0 0 0", fetch_err, pc, imem_req);
      end
      step();
      rst_n      = 1'b1;
      imem_ready = 1'b1;
      imem_rdata = 32'hFFFF_FFFF;
      step();
      imem_ready = 1'b0;
      tests_run++;
      if (imem_req !== 1'b1 || instr_valid !== 1'b0 || instr !== 32'h0 || imem_addr !== 32'h0) begin
         tests_failed++;
         $display("FAIL late_ready_idle: req=%b valid=%b instr=%h addr=%h, required 1 0 0 0",
                  imem_req, instr_valid, instr, imem_addr);
      end
   endtask

   task automatic test_reset_mid_fetch();
      rst_n = 1'b0;
      #1;
      tests_run++;
      if (imem_req !== 1'b0) begin
         tests_failed++;
         $display("FAIL midfetch_req_drop: req=%b, required 0", imem_req);
      end
      imem_ready = 1'b1;
      imem_rdata = 32'h1234_5678;
      step();
      imem_ready = 1'b0;
      tests_run++;
      if (instr_valid !== 1'b0 || instr !== 32'h0) begin
         tests_failed++;
         $display("FAIL midfetch_late_ready: valid=%b instr=%h, required 0 0", instr_valid, instr);
      end
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n      = 1'b0;
      imem_ready = 1'b0;
      imem_rdata = 32'h0;
      retire     = 1'b0;
      stall      = 1'b0;
      branch     = 1'b0;
      zero       = 1'b0;
      jump       = 1'b0;
      step();
      test_reset();
      test_sequential();
      test_branch();
      test_jal();
      test_stall();
      test_timeout();
      test_reset_mid_fetch();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
